seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a DIGITS-wide common-anode/cathode 7-segment display. It latches a packed BCD/hex word, scans one digit per refresh slot, and drives segment, decimal-point and digit-enable lines. It is the parametrised successor of the single-digit segment decoder: multi-digit, registered outputs, tear-free update and leading-zero blanking. It sits between the datapath producing display values and the board pins.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 39 +++
 rtl/seg7_scan_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment codes {g,f,e,d,c,b,a}
// (active-high) for 0-F and blank, digit width, and a polarity helper.
package seg7_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Converts an active-high segment pattern to pin polarity.
  function automatic logic [6:0] apply_pol7(input logic [6:0] pattern, input logic act_low);
    return pattern ^ {7{act_low}};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit to 7-segment decoder (active-high output).
// Hex glyphs for 10-15 are enabled by defining SEG7_HEX_EN; otherwise they decode blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  output logic [6:0]         seg
);

  // Digit value to segment pattern lookup.
  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
`ifdef SEG7_HEX_EN
      4'd10:   seg = SEG_A;
      4'd11:   seg = SEG_B;
      4'd12:   seg = SEG_C;
      4'd13:   seg = SEG_D;
      4'd14:   seg = SEG_E;
      4'd15:   seg = SEG_F;
`else
      4'd10, 4'd11, 4'd12,
      4'd13, 4'd14, 4'd15: seg = SEG_BLANK;
`endif
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-wide 7-segment driver with shadow/display double buffering,
// leading-zero blanking and registered pin outputs. Optional hex glyphs: SEG7_HEX_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIGIT_W*DIGITS-1:0] din,
  input  logic [DIGITS-1:0]       dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [DIGITS-1:0]       an,
  output logic                    frame_done
);

  localparam int VAL_W = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0]  presc_r;
  logic [IDX_W-1:0]  idx_r;
  logic [VAL_W-1:0]  shadow_val_r;
  logic [DIGITS-1:0] shadow_dp_r;
  logic [VAL_W-1:0]  disp_val_r;
  logic [DIGITS-1:0] disp_dp_r;
  logic              disp_blz_r;
  logic [6:0]        seg_r;
  logic              dp_r;
  logic [DIGITS-1:0] an_r;
  logic              frame_done_r;

  logic              presc_tc_s;
  logic              wrap_s;
  logic [DIGIT_W-1:0] sel_val_s;
  logic              sel_dp_s;
  logic              upper_zero_s;
  logic [DIGITS-1:0] an_onehot_s;
  logic              blank_s;
  logic [6:0]        dec_seg_s;
  logic [6:0]        seg_next_s;

  assign presc_tc_s = (presc_r == PRE_LAST);
  assign wrap_s     = presc_tc_s && (idx_r == IDX_LAST);

  // Refresh prescaler: one terminal count per digit slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (presc_tc_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRE_W'(1);
    end
  end

  // Digit index advances on each prescaler terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= '0;
    end else if (wrap_s) begin
      idx_r <= '0;
    end else if (presc_tc_s) begin
      idx_r <= idx_r + IDX_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Shadow capture; the last of several back-to-back loads wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val_r <= '0;
      shadow_dp_r  <= '0;
    end else if (load) begin
      shadow_val_r <= din;
      shadow_dp_r  <= dp_in;
    end else begin
      shadow_val_r <= shadow_val_r;
      shadow_dp_r  <= shadow_dp_r;
    end
  end

  // Display copy only at frame wrap, so a frame never mixes old and new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val_r <= '0;
      disp_dp_r  <= '0;
      disp_blz_r <= 1'b0;
    end else if (wrap_s) begin
      disp_val_r <= shadow_val_r;
      disp_dp_r  <= shadow_dp_r;
      disp_blz_r <= blank_lz;
    end else begin
      disp_val_r <= disp_val_r;
      disp_dp_r  <= disp_dp_r;
      disp_blz_r <= disp_blz_r;
    end
  end

  // Digit select, one-hot enable, and "this digit and all above are zero" detect.
  always_comb begin
    sel_val_s    = 4'h0;
    sel_dp_s     = 1'b0;
    upper_zero_s = 1'b1;
    an_onehot_s  = '0;
    for (int j = 0; j < DIGITS; j++) begin
      an_onehot_s[j] = (idx_r == IDX_W'(j));
      sel_val_s      = an_onehot_s[j] ? disp_val_r[j*DIGIT_W +: DIGIT_W] : sel_val_s;
      sel_dp_s       = an_onehot_s[j] ? disp_dp_r[j] : sel_dp_s;
      upper_zero_s   = ((IDX_W'(j) >= idx_r) && (disp_val_r[j*DIGIT_W +: DIGIT_W] != 4'h0))
                       ? 1'b0 : upper_zero_s;
    end
  end

  seg7_decode u_decode (
    .value (sel_val_s),
    .seg   (dec_seg_s)
  );

  assign blank_s    = disp_blz_r && (idx_r != IDX_W'(0)) && upper_zero_s;
  assign seg_next_s = blank_s ? SEG_BLANK : dec_seg_s;

  // Pin registers: polarity applied last, inactive level while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r        <= {7{POL}};
      dp_r         <= POL;
      an_r         <= {DIGITS{POL}};
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= apply_pol7(seg_next_s, POL);
      dp_r         <= sel_dp_s ^ POL;
      an_r         <= an_onehot_s ^ {DIGITS{POL}};
      frame_done_r <= wrap_s;
    end
  end

  assign seg        = seg_r;
  assign dp         = dp_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4) with a cycle-count
// reference model, plus an ACTIVE_LOW=1 instance for polarity and mid-frame reset.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

`ifdef SEG7_HEX_EN
  localparam logic [6:0] REF_TBL [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100, 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
`else
  localparam logic [6:0] REF_TBL [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic [15:0] din = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg, seg2;
  logic        dp, dp2;
  logic [3:0]  an, an2;
  logic        frame_done, fd2;

  int errors = 0;
  int checks = 0;

  seg7_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(DIV), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done));

  seg7_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(DIV), .ACTIVE_LOW(1)) dut_low (
    .clk(clk), .rst_n(rst2_n), .din(din), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
    .seg(seg2), .dp(dp2), .an(an2), .frame_done(fd2));

  always #5 clk = ~clk;

  // Reference model: digit shown is a function of cycles since reset release.
  int          t;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_shadow_dp, m_disp_dp;
  logic        m_blz;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;
  logic [3:0]  exp_an;

  function automatic int ref_digit(input int tn);
    return ((tn - 1) / DIV) % DIGITS;
  endfunction

  function automatic logic [6:0] ref_seg(input logic [15:0] word, input logic blz, input int k);
    logic [15:0] upper;
    upper = word >> (4 * k);
    if (blz && k != 0 && upper == 16'h0) return 7'b0000000;
    return REF_TBL[upper[3:0]];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= 0; m_shadow <= 16'h0; m_disp <= 16'h0; m_shadow_dp <= 4'h0; m_disp_dp <= 4'h0;
      m_blz <= 1'b0; exp_seg <= 7'h0; exp_dp <= 1'b0; exp_an <= 4'h0; exp_fd <= 1'b0;
    end else begin
      exp_an  <= 4'b0001 << ref_digit(t + 1);
      exp_seg <= ref_seg(m_disp, m_blz, ref_digit(t + 1));
      exp_dp  <= m_disp_dp[ref_digit(t + 1)];
      exp_fd  <= ((t + 1) % FRAME == 0);
      if ((t + 1) % FRAME == 0) begin
        m_disp <= m_shadow; m_disp_dp <= m_shadow_dp; m_blz <= blank_lz;
      end
      if (load) begin
        m_shadow <= din; m_shadow_dp <= dp_in;
      end
      t <= t + 1;
    end
  end

  task automatic test_reset();
    #12;
    checks++;
    if ({seg, dp, an, frame_done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_high actual seg=%b dp=%b an=%b fd=%b expected all 0", seg, dp, an, frame_done);
    end
    checks++;
    if ({seg2, dp2, an2, fd2} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL reset_low actual seg=%b dp=%b an=%b fd=%b expected 1111111 1 1111 0", seg2, dp2, an2, fd2);
    end
    @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;
  endtask

  task automatic test_scan();
    int fd_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      fd_count += frame_done ? 1 : 0;
      checks++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        errors++;
        $display("FAIL scan t=%0d actual seg=%b dp=%b an=%b fd=%b expected seg=%b dp=%b an=%b fd=%b",
                 t, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
      if (i == 0) begin
        checks++;
        if ({an, seg} !== {4'b0001, 7'b0111111}) begin
          errors++;
          $display("FAIL first_digit actual an=%b seg=%b expected an=0001 seg=0111111", an, seg);
        end
      end
    end
    checks++;
    if (fd_count != 2) begin
      errors++;
      $display("FAIL frame_period actual pulses=%0d expected 2 in 40 cycles", fd_count);
    end
  endtask

  task automatic test_load();
    logic [6:0] want [4] = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
    bit got = 1'b0;
    @(negedge clk); din = 16'h1234; dp_in = 4'b0100; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int k = 0; k < FRAME + 2 && !got; k++) begin
      @(negedge clk);
      got = frame_done;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL load_wait actual no frame_done expected within %0d", FRAME + 2); end
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        checks++;
        if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
          errors++;
          $display("FAIL load t=%0d actual seg=%b dp=%b an=%b fd=%b expected seg=%b dp=%b an=%b fd=%b",
                   t, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
        end
        if (c == 0) begin
          checks++;
          if ({an, seg, dp} !== {4'b0001 << d, want[d], d == 2}) begin
            errors++;
            $display("FAIL load_digit%0d actual an=%b seg=%b dp=%b expected seg=%b", d, an, seg, dp, want[d]);
          end
        end
      end
    end
  endtask

  task automatic test_blank();
    logic [15:0] words [2] = '{16'h0070, 16'h0000};
    logic [6:0]  want [2][4] = '{'{7'b0111111, 7'b0000111, 7'b0000000, 7'b0000000},
                                '{7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000}};
    for (int w = 0; w < 2; w++) begin
      bit got = 1'b0;
      @(negedge clk); blank_lz = 1'b1; din = words[w]; dp_in = 4'h0; load = 1'b1;
      @(negedge clk); load = 1'b0;
      for (int k = 0; k < FRAME + 2 && !got; k++) begin
        @(negedge clk);
        got = frame_done;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL blank_wait actual no frame_done expected within %0d", FRAME + 2); end
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < DIV; c++) begin
          @(negedge clk);
          checks++;
          if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
            errors++;
            $display("FAIL blank t=%0d actual seg=%b dp=%b an=%b fd=%b expected seg=%b dp=%b an=%b fd=%b",
                     t, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
          end
          if (c == 0) begin
            checks++;
            if (seg !== want[w][d]) begin
              errors++;
              $display("FAIL blank_w%0d_d%0d actual seg=%b expected seg=%b", w, d, seg, want[w][d]);
            end
          end
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_wrap_load();
    bit got = 1'b0;
    @(negedge clk); din = 16'h1234; dp_in = 4'h0; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int k = 0; k < FRAME + 2 && !got; k++) begin
      @(negedge clk);
      got = frame_done;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL wrap_wait actual no frame_done expected within %0d", FRAME + 2); end
    repeat (FRAME - 1) @(negedge clk);
    din = 16'h9999; load = 1'b1;
    @(negedge clk); load = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_edge actual fd=%b expected 1", frame_done);
    end
    for (int i = 1; i <= FRAME + 1; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        errors++;
        $display("FAIL wrap t=%0d actual seg=%b dp=%b an=%b fd=%b expected seg=%b dp=%b an=%b fd=%b",
                 t, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
      if (i == 1 || i == FRAME + 1) begin
        checks++;
        if ({an, seg} !== {4'b0001, (i == 1) ? 7'b1100110 : 7'b1101111}) begin
          errors++;
          $display("FAIL wrap_frame%0d actual an=%b seg=%b expected an=0001 seg=%b",
                   i, an, seg, (i == 1) ? 7'b1100110 : 7'b1101111);
        end
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] want [4];
    bit got = 1'b0;
`ifdef SEG7_HEX_EN
    want = '{7'b1011110, 7'b0111001, 7'b1111100, 7'b1110111};
`else
    want = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
`endif
    @(negedge clk); din = 16'hABCD; dp_in = 4'h0; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int k = 0; k < FRAME + 2 && !got; k++) begin
      @(negedge clk);
      got = frame_done;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL hex_wait actual no frame_done expected within %0d", FRAME + 2); end
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        if (c == 0) begin
          checks++;
          if ({an, seg} !== {4'b0001 << d, want[d]}) begin
            errors++;
            $display("FAIL hex_digit%0d actual an=%b seg=%b expected seg=%b", d, an, seg, want[d]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    for (int i = 0; i < 192; i++) begin
      din      = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      load     = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      checks++;
      if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
        errors++;
        $display("FAIL random t=%0d actual seg=%b dp=%b an=%b fd=%b expected seg=%b dp=%b an=%b fd=%b",
                 t, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
      end
    end
    load = 1'b0; blank_lz = 1'b0;
  endtask

  task automatic test_active_low();
    logic [3:0] want_an;
    @(negedge clk); din = 16'h1234; dp_in = 4'b1111; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst2_n = 1'b0;
    #1;
    checks++;
    if ({seg2, dp2, an2, fd2} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL low_reset actual seg=%b dp=%b an=%b fd=%b expected 1111111 1 1111 0", seg2, dp2, an2, fd2);
    end
    @(negedge clk); rst2_n = 1'b1;
    for (int n = 1; n <= 2 * FRAME + 4; n++) begin
      @(negedge clk);
      want_an = ~(4'b0001 << (((n - 1) / DIV) % DIGITS));
      checks++;
      if ({seg2, dp2, an2, fd2} !== {7'b1000000, 1'b1, want_an, (n % FRAME == 0)}) begin
        errors++;
        $display("FAIL low_scan n=%0d actual seg=%b dp=%b an=%b fd=%b expected seg=1000000 dp=1 an=%b",
                 n, seg2, dp2, an2, fd2, want_an);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_blank();
    test_wrap_load();
    test_hex();
    test_random();
    test_active_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual time limit reached expected completion");
    $fatal(1, "watchdog");
  end

endmodule
